// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiply, with registered result and status flags.
//
// state | meaning
// IDLE  | waiting for START; single-cycle ops complete here
// MULT  | shift-add multiply in progress, BUSY high
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVERFLOW,
  output logic             ERROR,
  output logic             DONE,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_FWD = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic {IDLE, MULT} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;

  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   c_res;
  logic               c_ovf;
  logic               c_err;
  logic [2*WIDTH-1:0] acc_nxt;

  // Single-cycle datapath, evaluated from the live inputs.
  always_comb begin
    shamt = DATA2[SHW-1:0];
    sum   = DATA1 + DATA2;
    diff  = DATA1 - DATA2;
    rot   = {DATA1, DATA1} >> shamt;
    c_res = '0;
    c_ovf = 1'b0;
    c_err = 1'b0;
    case (SELECT)
      OP_FWD: c_res = DATA2;
      OP_ADD: begin
        c_res = sum;
        c_ovf = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (sum[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_AND: c_res = DATA1 & DATA2;
      OP_OR:  c_res = DATA1 | DATA2;
      OP_SLL: c_res = DATA1 << shamt;
      OP_SRL: c_res = DATA1 >> shamt;
      OP_SRA: c_res = $signed(DATA1) >>> shamt;
      OP_ROR: c_res = rot[WIDTH-1:0];
      OP_SUB: begin
        c_res = diff;
        c_ovf = (DATA1[WIDTH-1] != DATA2[WIDTH-1]) && (diff[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_MUL: c_res = '0;
      default: c_err = 1'b1;
    endcase
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      RESULT   <= '0;
      ZERO     <= 1'b0;
      NEG      <= 1'b0;
      OVERFLOW <= 1'b0;
      ERROR    <= 1'b0;
      DONE     <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (SELECT == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, DATA1};
              mplier <= DATA2;
              acc    <= '0;
              cnt    <= CW'(WIDTH);
              BUSY   <= 1'b1;
              state  <= MULT;
            end else begin
              RESULT   <= c_res;
              ZERO     <= (c_res == '0);
              NEG      <= c_res[WIDTH-1];
              OVERFLOW <= c_ovf;
              ERROR    <= c_err;
              DONE     <= 1'b1;
            end
          end
        end
        MULT: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt - 1'b1;
          // Last step: publish the product from the value being written to acc.
          if (cnt == CW'(1)) begin
            RESULT   <= acc_nxt[WIDTH-1:0];
            ZERO     <= (acc_nxt[WIDTH-1:0] == '0);
            NEG      <= acc_nxt[WIDTH-1];
            OVERFLOW <= |acc_nxt[2*WIDTH-1:WIDTH];
            ERROR    <= 1'b0;
            DONE     <= 1'b1;
            BUSY     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         START = 1'b0;
  logic [3:0]   SELECT = '0;
  logic [W-1:0] DATA1 = '0;
  logic [W-1:0] DATA2 = '0;
  logic [W-1:0] RESULT;
  logic         ZERO, NEG, OVERFLOW, ERROR, DONE, BUSY;

  int n_vec = 0;
  int n_mis = 0;

  int e_res = 0, e_z = 0, e_n = 0, e_o = 0, e_e = 0;

  alu_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO),
    .NEG(NEG), .OVERFLOW(OVERFLOW), .ERROR(ERROR), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  // Expected outcome from the operation's arithmetic definition.
  function automatic void model(input int sel, input int a, input int b,
                                output int r, output int o, output int e);
    int sh, s, p;
    sh = b % W;
    r = 0; o = 0; e = 0;
    case (sel)
      0: r = b;
      1: begin s = sx(a) + sx(b); r = (a + b) % MOD; o = (s > HALF - 1 || s < -HALF) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = (a << sh) % MOD;
      5: r = a >> sh;
      6: r = (sx(a) >>> sh) & (MOD - 1);
      7: r = ((a >> sh) | (a << (W - sh))) & (MOD - 1);
      8: begin s = sx(a) - sx(b); r = (a - b + MOD) % MOD; o = (s > HALF - 1 || s < -HALF) ? 1 : 0; end
      9: begin p = a * b; r = p % MOD; o = (p >= MOD) ? 1 : 0; end
      default: e = 1;
    endcase
  endfunction

  task automatic expect_op(input int sel, input int a, input int b);
    model(sel, a, b, e_res, e_o, e_e);
    e_z = (e_res == 0) ? 1 : 0;
    e_n = (e_res >= HALF) ? 1 : 0;
  endtask

  task automatic check_all(input string tag, input int exp_done, input int exp_busy);
    chk({tag, ".res"},  int'(RESULT),   e_res);
    chk({tag, ".zero"}, int'(ZERO),     e_z);
    chk({tag, ".neg"},  int'(NEG),      e_n);
    chk({tag, ".ovf"},  int'(OVERFLOW), e_o);
    chk({tag, ".err"},  int'(ERROR),    e_e);
    chk({tag, ".done"}, int'(DONE),     exp_done);
    chk({tag, ".busy"}, int'(BUSY),     exp_busy);
  endtask

  task automatic single(input string tag, input int sel, input int a, input int b);
    @(negedge CLK);
    START = 1'b1; SELECT = 4'(sel); DATA1 = W'(a); DATA2 = W'(b);
    @(posedge CLK); #1;
    START = 1'b0; DATA1 = W'($urandom); DATA2 = W'($urandom);
    expect_op(sel, a, b);
    check_all(tag, 1, 0);
  endtask

  task automatic idle(input string tag);
    @(negedge CLK);
    SELECT = 4'($urandom); DATA1 = W'($urandom);
    @(posedge CLK); #1;
    check_all(tag, 0, 0);
  endtask

  // inject: MULT cycle in which a stray ADD request is driven (0 = none)
  task automatic mul(input string tag, input int a, input int b, input int inject);
    @(negedge CLK);
    START = 1'b1; SELECT = 4'd9; DATA1 = W'(a); DATA2 = W'(b);
    @(posedge CLK); #1;
    START = 1'b0; DATA1 = W'($urandom); DATA2 = W'($urandom);
    check_all({tag, ".e0"}, 0, 1);
    for (int i = 1; i <= W; i++) begin
      if (i == inject) begin
        @(negedge CLK);
        START = 1'b1; SELECT = 4'd1; DATA1 = W'($urandom); DATA2 = W'($urandom);
      end
      @(posedge CLK); #1;
      START = 1'b0;
      if (i < W) begin
        chk({tag, ".busy"}, int'(BUSY), 1);
        chk({tag, ".done"}, int'(DONE), 0);
        chk({tag, ".hold"}, int'(RESULT), e_res);
      end else begin
        expect_op(9, a, b);
        check_all({tag, ".end"}, 1, 0);
      end
    end
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, a, b;
    #12;
    check_all("reset", 0, 0);
    @(negedge CLK); RESET = 1'b1;

    single("add25_41", 1, 25, 41);
    chk("add25_41.lit", int'(RESULT), 66);
    single("sub14_14", 8, 14, 14);
    chk("sub14_14.zlit", int'(ZERO), 1);
    idle("idle1");
    single("add100", 1, 100, 100);
    chk("add100.ovflit", int'(OVERFLOW), 1);
    single("sra", 6, 'h96, 2);
    chk("sra.lit", int'(RESULT), 'hE5);
    single("ror", 7, 'h96, 3);
    chk("ror.lit", int'(RESULT), 'hD2);
    single("sll8", 4, 'h96, 8);
    chk("sll8.lit", int'(RESULT), 'h96);
    mul("mul13_11", 13, 11, 0);
    chk("mul13_11.lit", int'(RESULT), 143);
    idle("idle2");
    mul("mul20_20", 20, 20, 0);
    chk("mul20_20.ovflit", int'(OVERFLOW), 1);
    mul("mul_inj", 27, 9, 3);
    idle("idle3");
    single("sub_ovf", 8, 'h80, 1);
    single("srl", 5, 'hF0, 4);

    // Reset during a multiply: outputs clear at once, no completion appears.
    @(negedge CLK);
    START = 1'b1; SELECT = 4'd9; DATA1 = 8'd7; DATA2 = 8'd9;
    @(posedge CLK); #1; START = 1'b0;
    for (int i = 1; i <= 3; i++) begin @(posedge CLK); #1; end
    #2; RESET = 1'b0; #1;
    e_res = 0; e_z = 0; e_n = 0; e_o = 0; e_e = 0;
    check_all("rst_abort", 0, 0);
    for (int i = 0; i < W; i++) begin
      @(posedge CLK); #1;
      chk("rst_nodone", int'(DONE), 0);
    end
    @(negedge CLK); RESET = 1'b1;
    single("illegal12", 12, $urandom_range(0, 255), $urandom_range(0, 255));
    chk("illegal12.errlit", int'(ERROR), 1);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 15);
      a = $urandom_range(0, MOD - 1);
      b = $urandom_range(0, MOD - 1);
      if (sel == 9) mul("rnd_mul", a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : 0);
      else if ($urandom_range(0, 7) == 0) idle("rnd_idle");
      else single("rnd", sel, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
